// File: rtl/pm_pkg.sv
// ---------------------------------------------------------------------------
// pm_pkg
// Shared definitions for the parking-meter timer responder.
//   CNT_W       width of the tick-remaining and completed-run counters
//   pm_state_e  timer FSM state encoding (IDLE, RUN, GAP)
//   cnt_inc     modulo-2^CNT_W increment used by the run counter
// ---------------------------------------------------------------------------
package pm_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } pm_state_e;

  // Wrapping increment; 15 rolls over to 0.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return v + 4'd1;
  endfunction

endpackage

// File: rtl/pm_prescaler.sv
// ---------------------------------------------------------------------------
// pm_prescaler
// Modulo-PRESCALE cycle counter that produces one timer tick per PRESCALE
// enabled clock cycles.
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset
//   en   in   count enable
//   clr  in   synchronous clear (wins over en)
//   tc   out  terminal-count pulse; high in the enabled cycle in which the
//             counter sits at PRESCALE-1 (every enabled cycle when PRESCALE=1)
// ---------------------------------------------------------------------------
module pm_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Next count and terminal-count decode.
  always_comb begin
    cnt_d = cnt_q;
    tc    = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tc    = 1'b1;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pm_timer.sv
// ---------------------------------------------------------------------------
// pm_timer
// Timer responder for the parking-meter controller. A rising edge on ct
// starts a run: t is driven low for TICKS*PRESCALE cycles, then held high
// for at least GAP cycles before another run may start. One extra request
// arriving during RUN/GAP is queued.
// Parameters:
//   PRESCALE  clock cycles per tick (>=1)
//   TICKS     ticks per run (1..15)
//   GAP       minimum high cycles between consecutive runs (>=1)
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   ct    in   start-timer request (rising edge = one request)
//   clr   in   synchronous abort; drops run and pending request
//   t     out  timer line, idles high, low while running
//   rem   out  ticks remaining in the current run, 0 when not running
//   done  out  one-cycle pulse as t returns high after a completed run
//   runs  out  completed-run count, wraps 15->0
//   busy  out  high in RUN or GAP
// All outputs are registered.
// ---------------------------------------------------------------------------
module pm_timer
  import pm_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned TICKS    = 4,
  parameter int unsigned GAP      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ct,
  input  logic             clr,
  output logic             t,
  output logic [CNT_W-1:0] rem,
  output logic             done,
  output logic [CNT_W-1:0] runs,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TICKS_V  = CNT_W'(TICKS);
  localparam int unsigned      GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP - 1);

  pm_state_e        state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] runs_q, runs_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;
  logic             t_q, t_d;
  logic             busy_q, busy_d;
  logic             ct_prev_q;
  logic             req_s;
  logic             tick_s;
  logic             pre_clr_s;
  logic             pre_en_s;

  // A held ct is one request: only a 0->1 transition counts.
  assign req_s = ct & ~ct_prev_q;

  // The prescaler is held at zero outside RUN so every run starts on a
  // fresh tick boundary.
  assign pre_en_s  = (state_q == ST_RUN);
  assign pre_clr_s = (state_q != ST_RUN) | clr;

  pm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk(clk),
    .rst(rst),
    .en (pre_en_s),
    .clr(pre_clr_s),
    .tc (tick_s)
  );

  // Next-state, counters, pending latch and output decode.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    runs_d  = runs_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d = ST_RUN;
          rem_d   = TICKS_V;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // A request arriving on the completing cycle still lands here and
        // is served after the gap.
        if (req_s) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (tick_s) begin
          if (rem_q == 4'd1) begin
            state_d = ST_GAP;
            rem_d   = 4'd0;
            done_d  = 1'b1;
            runs_d  = cnt_inc(runs_q);
            gap_d   = '0;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end else begin
          rem_d = rem_q;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          // A request on the exit cycle itself is honoured like a pending one.
          if (pend_q || req_s) begin
            state_d = ST_RUN;
            rem_d   = TICKS_V;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
          if (req_s) begin
            pend_d = 1'b1;
          end else begin
            pend_d = pend_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        rem_d   = 4'd0;
        pend_d  = 1'b0;
        gap_d   = '0;
      end
    endcase

    // Abort overrides everything above except the completed-run count.
    if (clr) begin
      state_d = ST_IDLE;
      rem_d   = 4'd0;
      pend_d  = 1'b0;
      done_d  = 1'b0;
      gap_d   = '0;
      runs_d  = runs_q;
    end else begin
      runs_d = runs_d;
    end

    t_d    = (state_d != ST_RUN);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= 4'd0;
      runs_q    <= 4'd0;
      gap_q     <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      t_q       <= 1'b1;
      busy_q    <= 1'b0;
      ct_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      runs_q    <= runs_d;
      gap_q     <= gap_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      t_q       <= t_d;
      busy_q    <= busy_d;
      ct_prev_q <= ct;
    end
  end

  assign t    = t_q;
  assign rem  = rem_q;
  assign done = done_q;
  assign runs = runs_q;
  assign busy = busy_q;

endmodule

// File: doc/pm_timer.md
Name: pm_timer

Overview:
- Timer responder for the parking-meter controller's timer handshake.
- The controller raises `ct` to request one timing cycle. This block drives the `t` line low for a fixed duration, then returns it high.
- Supports back-to-back requests, one of which may be queued.
- Reports the ticks remaining in the current run and the number of completed runs for the display/debug path.
- Sits beside the meter FSM on the same clock; `t` connects directly to the FSM's `t` input.

Parameters:
- PRESCALE, 1, clock cycles per timer tick (≥1; 1 for simulation, large for board clock).
- TICKS, 4, ticks per timing cycle (≥1, ≤15).
- GAP, 1, minimum clock cycles `t` stays high between consecutive runs (≥1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- ct  in  1  start-timer request from meter FSM, sampled each rising edge.
- clr  in  1  synchronous abort: ends the current run and drops any pending request.
- t  out  1  timer line; idles high, low while timing.
- rem  out  4  ticks remaining in the current run; 0 when not running.
- done  out  1  one-cycle pulse on the cycle `t` returns high after a run completes (not after an abort).
- runs  out  4  completed-run count, wraps 15→0.
- busy  out  1  high in RUN or GAP state.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, t=1, rem=0, done=0, runs=0, busy=0, pending=0, counters=0.
- States:
  - IDLE: t=1.
  - RUN: t=0.
  - GAP: t=1 for GAP cycles.
- IDLE→RUN: `ct` sampled high at edge k. At edge k, t goes 0, rem=TICKS, and the prescale counter is cleared. Latency from `ct` to `t` low is one edge.
- RUN:
  - The prescale counter counts 0..PRESCALE-1. On terminal count, rem decrements.
  - When rem would reach 0: enter GAP, t=1, done=1 for one cycle, runs+=1 (mod 16).
  - `t` is low for exactly TICKS*PRESCALE cycles.
- GAP: hold t=1 for GAP cycles, then:
  - pending=1 → RUN (clear pending, reload rem=TICKS);
  - otherwise → IDLE.
- Queuing:
  - `ct` high in RUN or GAP sets pending (one-deep). Further requests while pending=1 are dropped.
  - `ct` held high continuously counts as one request per run. The level is re-sampled only in IDLE, plus the single pending latch.
- Rule for `ct` in IDLE: a run starts only on a rising edge of `ct`. The previous sampled value of `ct` is kept in a register. This keeps a held `ct` from retriggering indefinitely.
- `clr` (priority over `ct` in the same cycle):
  - any state → IDLE next edge; t=1, rem=0, pending=0, done=0;
  - runs is unchanged.
- Simultaneous completion and `ct` in the same cycle: the request goes to pending and starts after GAP.
- PRESCALE=1: rem decrements every cycle in RUN.
- Outputs are registered. No combinational path from `ct` to `t`.

Decomposition:
- Package pm_pkg: state encoding localparams (IDLE, RUN, GAP), 4-bit count width constant.
- One sub-module is natural: pm_prescaler (PRESCALE-modulo counter with enable, sync clear, terminal-count pulse).
- The FSM, tick counter, pending latch and run counter stay in pm_timer.

Test Plan:
- Defaults (PRESCALE=1, TICKS=4, GAP=1); reset, then `ct` pulse 1 cycle → t low exactly 4 cycles starting one edge after `ct`; rem 4,3,2,1 then 0; done pulse 1 cycle as t rises; runs=1.
- Second `ct` pulse issued during RUN → pending. After completion, t stays high 1 cycle (GAP), then low 4 more cycles; runs=2; two done pulses.
- `ct` held high 20 cycles from IDLE → exactly one run (plus at most one pending run), then IDLE with t=1; runs increments by ≤2.
- PRESCALE=3, TICKS=2 → t low 6 cycles; rem decrements every 3rd cycle.
- `clr` asserted in cycle 2 of RUN with pending set → t=1 next edge, rem=0, no done, pending cleared, runs unchanged; next `ct` starts a fresh 4-cycle run.
- `rst` asserted asynchronously mid-RUN (between edges) → t=1 immediately; rem, runs, busy all 0. Run 17 complete cycles → runs wraps to 1.
